// File: rtl/fifo_pack_pkg.sv
// Shared definitions for the write-side byte packer feeding FIFO_syn.
// Holds the packer state encoding, default geometry and checksum seed.
package fifo_pack_pkg;

    localparam int LANES_DEF = 4;
    localparam int WIDTH_DEF = 8;

    localparam logic [7:0] CKSUM_SEED = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        CKSUM = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_byte_packer.sv
// Serializes 32-bit words LSB-byte-first into the FIFO write port and appends
// an XOR checksum byte per frame; holds winc/wdata stable while wfull is high.
module fifo_byte_packer
    import fifo_pack_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 16
) (
    input  logic                   wclk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic [1:0]             in_nbytes,
    input  logic                   in_last,
    output logic                   winc,
    output logic [WIDTH-1:0]       wdata,
    input  logic                   wfull,
    output logic                   frame_done,
    output logic [CNT_W-1:0]       frame_cnt
);

    state_t                 r_state;
    logic [LANES*WIDTH-1:0] r_word;
    logic [1:0]             r_nb;
    logic                   r_last;
    logic [1:0]             r_idx;
    logic [WIDTH-1:0]       r_cksum;
    logic                   r_frame_done;
    logic [CNT_W-1:0]       r_frame_cnt;

    state_t                 w_nxt_state;
    logic [LANES*WIDTH-1:0] w_nxt_word;
    logic [1:0]             w_nxt_nb;
    logic                   w_nxt_last;
    logic [1:0]             w_nxt_idx;
    logic [WIDTH-1:0]       w_nxt_cksum;
    logic                   w_nxt_frame_done;
    logic [CNT_W-1:0]       w_nxt_frame_cnt;

    logic [WIDTH-1:0]       w_byte;
    logic                   w_acc;
    logic                   w_word_end;

    // Current data byte, selected from registers only.
    always_comb begin
        w_byte = '0;
        for (int i = 0; i < LANES; i++) begin
            if (r_idx == i[1:0]) begin
                w_byte = r_word[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_acc      = winc && !wfull;
    assign w_word_end = (r_idx == r_nb);

    always_comb begin
        winc  = 1'b0;
        wdata = '0;
        unique case (r_state)
            DATA: begin
                winc  = 1'b1;
                wdata = w_byte;
            end
            CKSUM: begin
                winc  = 1'b1;
                wdata = r_cksum;
            end
            default: begin
                winc  = 1'b0;
                wdata = '0;
            end
        endcase
    end

    // A new word may enter while the last byte of a non-final word leaves.
    assign in_ready = (r_state == IDLE) ||
                      ((r_state == DATA) && w_acc && w_word_end && !r_last);

    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_word       = r_word;
        w_nxt_nb         = r_nb;
        w_nxt_last       = r_last;
        w_nxt_idx        = r_idx;
        w_nxt_cksum      = r_cksum;
        w_nxt_frame_done = 1'b0;
        w_nxt_frame_cnt  = r_frame_cnt;
        unique case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_nxt_word  = in_data;
                    w_nxt_nb    = in_nbytes;
                    w_nxt_last  = in_last;
                    w_nxt_idx   = 2'd0;
                    w_nxt_state = DATA;
                end
            end
            DATA: begin
                if (w_acc) begin
                    w_nxt_cksum = r_cksum ^ w_byte;
                    if (r_idx < r_nb) begin
                        w_nxt_idx = r_idx + 2'd1;
                    end else if (r_last) begin
                        w_nxt_state = CKSUM;
                    end else if (in_valid) begin
                        w_nxt_word = in_data;
                        w_nxt_nb   = in_nbytes;
                        w_nxt_last = in_last;
                        w_nxt_idx  = 2'd0;
                    end else begin
                        w_nxt_state = IDLE;
                    end
                end
            end
            CKSUM: begin
                if (w_acc) begin
                    w_nxt_cksum      = WIDTH'(CKSUM_SEED);
                    w_nxt_frame_done = 1'b1;
                    w_nxt_frame_cnt  = r_frame_cnt + CNT_W'(1);
                    w_nxt_state      = IDLE;
                end
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_word       <= '0;
            r_nb         <= '0;
            r_last       <= 1'b0;
            r_idx        <= '0;
            r_cksum      <= WIDTH'(CKSUM_SEED);
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_state      <= w_nxt_state;
            r_word       <= w_nxt_word;
            r_nb         <= w_nxt_nb;
            r_last       <= w_nxt_last;
            r_idx        <= w_nxt_idx;
            r_cksum      <= w_nxt_cksum;
            r_frame_done <= w_nxt_frame_done;
            r_frame_cnt  <= w_nxt_frame_cnt;
        end
    end

    assign frame_done = r_frame_done;
    assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Scoreboard bench for fifo_byte_packer: stimulus queues hand-computed bytes,
// a negedge monitor pops and compares every byte the FIFO would accept.
module tb_fifo_byte_packer;

    localparam int LANES = 4;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic                   wclk;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*WIDTH-1:0] in_data;
    logic [1:0]             in_nbytes;
    logic                   in_last;
    logic                   winc;
    logic [WIDTH-1:0]       wdata;
    logic                   wfull;
    logic                   frame_done;
    logic [CNT_W-1:0]       frame_cnt;

    fifo_byte_packer #(
        .LANES(LANES),
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .wclk      (wclk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_nbytes (in_nbytes),
        .in_last   (in_last),
        .winc      (winc),
        .wdata     (wdata),
        .wfull     (wfull),
        .frame_done(frame_done),
        .frame_cnt (frame_cnt)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int nacc   = 0;
    int done_cnt = 0;
    int hs_cyc = 0;
    logic [7:0] exp_q[$];
    int         acc_cyc[$];

    always @(posedge wclk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a byte is accepted at the coming rising edge if winc && !wfull now.
    always @(negedge wclk) begin
        if (rst_n && winc && !wfull) begin
            nacc = nacc + 1;
            acc_cyc.push_back(cyc + 1);
            if (exp_q.size() == 0) begin
                chk("unexpected_byte", 32'(wdata), 32'hFFFF_FFFF);
            end else begin
                chk("wdata", 32'(wdata), 32'(exp_q.pop_front()));
            end
        end
        if (frame_done) done_cnt = done_cnt + 1;
    end

    task automatic push3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
    endtask

    task automatic send_word(input logic [31:0] d, input logic [1:0] nb, input logic lst);
        in_data   = d;
        in_nbytes = nb;
        in_last   = lst;
        in_valid  = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge wclk);
            if (in_ready) begin
                hs_cyc = cyc + 1;
                @(posedge wclk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        chk("handshake_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_nacc(input int n);
        for (int k = 0; k < 200; k++) begin
            @(posedge wclk);
            #1;
            if (nacc >= n) return;
        end
        chk("wait_bytes_timeout", 32'(nacc), 32'(n));
    endtask

    task automatic drain();
        for (int k = 0; k < 300; k++) begin
            if (exp_q.size() == 0) break;
            @(posedge wclk);
            #1;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge wclk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_winc"},       32'(winc),       32'd0);
        chk({tag, "_wdata"},      32'(wdata),      32'd0);
        chk({tag, "_in_ready"},   32'(in_ready),   32'd1);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_frame_cnt"},  32'(frame_cnt),  32'd0);
    endtask

    int nacc0;
    int done0;
    int hs_b;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_nbytes = '0;
        in_last   = 1'b0;
        wfull     = 1'b0;
        #1;
        check_reset_outputs("reset0");
        repeat (2) @(posedge wclk);
        #1;
        rst_n = 1'b1;
        @(posedge wclk);
        #1;

        // Single frame, no backpressure
        nacc0 = nacc; done0 = done_cnt; acc_cyc.delete();
        push3(8'h11, 8'h22, 8'h33);
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h44);
        send_word(32'h44332211, 2'd3, 1'b1);
        drain();
        chk("s1_nbytes", 32'(nacc - nacc0), 32'd5);
        chk("s1_latency", 32'(acc_cyc[0]), 32'(hs_cyc + 1));
        chk("s1_no_bubble", 32'(acc_cyc[4] - acc_cyc[0]), 32'd4);
        chk("s1_done_pulses", 32'(done_cnt - done0), 32'd1);
        chk("s1_frame_cnt", 32'(frame_cnt), 32'd1);

        // Back-to-back words in one frame
        nacc0 = nacc; done0 = done_cnt; acc_cyc.delete();
        push3(8'h01, 8'h02, 8'h03);
        push3(8'h04, 8'hAA, 8'hAE);
        send_word(32'h04030201, 2'd3, 1'b0);
        send_word(32'h000000AA, 2'd0, 1'b1);
        hs_b = hs_cyc;
        drain();
        chk("s2_nbytes", 32'(nacc - nacc0), 32'd6);
        chk("s2_no_bubble", 32'(acc_cyc[5] - acc_cyc[0]), 32'd5);
        chk("s2_b_accept_edge", 32'(hs_b), 32'(acc_cyc[3]));
        chk("s2_frame_cnt", 32'(frame_cnt), 32'd2);

        // Backpressure after byte 22
        nacc0 = nacc; done0 = done_cnt; acc_cyc.delete();
        push3(8'h11, 8'h22, 8'h33);
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h44);
        send_word(32'h44332211, 2'd3, 1'b1);
        wait_nacc(nacc0 + 2);
        wfull = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge wclk);
            chk("s3_hold_winc", 32'(winc), 32'd1);
            chk("s3_hold_wdata", 32'(wdata), 32'h33);
        end
        chk("s3_stalled_count", 32'(nacc - nacc0), 32'd2);
        @(posedge wclk);
        #1;
        wfull = 1'b0;
        drain();
        chk("s3_nbytes", 32'(nacc - nacc0), 32'd5);
        chk("s3_done_pulses", 32'(done_cnt - done0), 32'd1);
        chk("s3_frame_cnt", 32'(frame_cnt), 32'd3);

        // Partial word: only two bytes
        nacc0 = nacc; acc_cyc.delete();
        push3(8'hEF, 8'hBE, 8'h51);
        send_word(32'hDEADBEEF, 2'd1, 1'b1);
        drain();
        chk("s4_nbytes", 32'(nacc - nacc0), 32'd3);
        chk("s4_frame_cnt", 32'(frame_cnt), 32'd4);

        // Reset mid-frame after byte 22
        nacc0 = nacc; acc_cyc.delete();
        push3(8'h11, 8'h22, 8'h33);
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h44);
        send_word(32'h44332211, 2'd3, 1'b1);
        wait_nacc(nacc0 + 2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("s5_reset");
        exp_q.delete();
        repeat (3) @(posedge wclk);
        #1;
        chk("s5_no_write_in_reset", 32'(nacc - nacc0), 32'd2);
        rst_n = 1'b1;
        @(posedge wclk);
        #1;
        nacc0 = nacc; done0 = done_cnt;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h55);
        send_word(32'h00000055, 2'd0, 1'b1);
        drain();
        chk("s5_nbytes", 32'(nacc - nacc0), 32'd2);
        chk("s5_done_pulses", 32'(done_cnt - done0), 32'd1);
        chk("s5_frame_cnt", 32'(frame_cnt), 32'd1);

        // Counter wrap with CNT_W=4
        rst_n = 1'b0;
        #1;
        chk("s6_reset_cnt", 32'(frame_cnt), 32'd0);
        @(posedge wclk);
        #1;
        rst_n = 1'b1;
        @(posedge wclk);
        #1;
        done0 = done_cnt;
        for (int i = 0; i < 15; i++) begin
            exp_q.push_back(8'(8'h10 + i));
            exp_q.push_back(8'(8'h10 + i));
            send_word(32'(8'h10 + i), 2'd0, 1'b1);
        end
        drain();
        chk("s6_cnt_15", 32'(frame_cnt), 32'd15);
        exp_q.push_back(8'h1F);
        exp_q.push_back(8'h1F);
        send_word(32'h0000001F, 2'd0, 1'b1);
        drain();
        chk("s6_cnt_wrap", 32'(frame_cnt), 32'd0);
        chk("s6_done_pulses", 32'(done_cnt - done0), 32'd16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_byte_packer.md
# fifo_byte_packer

Write-side producer for the asynchronous FIFO_syn in the wclk domain. Accepts 32-bit words on a valid/ready handshake, serializes them LSB-byte-first into the FIFO's 8-bit write port, and appends an XOR checksum byte after the last word of each frame. It honours `wfull` so no byte is ever dropped, and exports frame-completion status to local control.

## Interface
- `LANES`, default 4: bytes per input word.
- `WIDTH`, default 8: byte width; must match the FIFO `WIDTH`.
- `CNT_W`, default 16: frame counter width.

Ports (name, direction, width, meaning):
- `wclk`  in  1  write-domain clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  input word accepted when `in_valid && in_ready` at the rising edge.
- `in_data`  in  `LANES*WIDTH`  word; byte 0 is `[7:0]`.
- `in_nbytes`  in  2  number of valid bytes minus 1 (0 means 1 byte, 3 means 4 bytes).
- `in_last`  in  1  word ends the frame.
- `winc`  out  1  FIFO write request.
- `wdata`  out  `WIDTH`  FIFO write data.
- `wfull`  in  1  FIFO full; registered in the FIFO.
- `frame_done`  out  1  one-cycle pulse when a checksum byte is accepted.
- `frame_cnt`  out  `CNT_W`  count of completed frames; wraps modulo 2^`CNT_W`.

## Operation
- Byte acceptance: `acc = winc && !wfull` at a rising edge. The FIFO drops writes made while `wfull=1`. The packer therefore holds `winc`/`wdata` stable until `acc`.
- `winc` and `wdata` decode from registers only (state, word register, `idx`, `cksum`). There is no combinational path from input to `winc`.
- States and transitions:
  - **IDLE**
    - `winc=0`, `wdata=0`, `in_ready=1`.
    - On handshake: latch `word`, `nb`, `last`; set `idx=0`; go to DATA.
  - **DATA**
    - `winc=1`, `wdata=word[idx]`.
    - On `acc`: `cksum ^= word[idx]`.
    - If `idx<nb`: `idx++`.
    - Else if `last`: go to CKSUM.
    - Else if `in_valid`: load the new word, set `idx=0`, stay in DATA (back-to-back).
    - Else: go to IDLE.
  - **CKSUM**
    - `winc=1`, `wdata=cksum`, `in_ready=0`.
    - On `acc`: `cksum<=0`, `frame_done=1` for one cycle, `frame_cnt++`, go to IDLE.
- `in_ready = (state==IDLE) || (state==DATA && acc && idx==nb && !last)`. This is combinational from registered `wfull`.
- Checksum is the XOR of all accepted data bytes of the frame, seeded with 0.
  - Bytes above `nb` are ignored and not XORed.
  - A 1-byte frame with data `D` emits `D`, then `D`.
- `wfull` stuck high: the block holds its state indefinitely. Nothing is lost or duplicated.
- `wfull` rising at the edge of an accepted byte: the next byte is presented and held until `wfull` falls.
- Reset, including mid-frame: all registers clear immediately.
  - The partial frame is discarded and no checksum is emitted.
  - `winc=0` from reset assertion onward.

## Timing
- Reset values:
  - `in_ready=1` (IDLE).
  - `winc=0`, `wdata=0`, `frame_done=0`, `frame_cnt=0`.
  - Internal: `cksum=0`, `idx=0`.
- Latency: handshake at edge N puts byte 0 on `winc`/`wdata` in the cycle after N. With `wfull=0` it is accepted at edge N+1.
- Throughput: 1 byte per cycle while `wfull=0`. Consecutive words of a frame have no bubble.
- Per frame: 1 checksum cycle, plus 1 IDLE cycle before the next frame's first word is accepted.
- `frame_done` is high in the cycle after the checksum byte's `acc` edge, coincident with the updated `frame_cnt`.

## Structure
- Shared package `fifo_pack_pkg` holds:
  - state enum `{IDLE, DATA, CKSUM}`;
  - `LANES` and `WIDTH` defaults;
  - `CKSUM_SEED = 8'h00`.
- Single module, no sub-module. The byte select is an indexed part-select inside the block.

## Test plan
- **Single frame, no backpressure.** One word `32'h44332211`, `nb=3`, `last=1`, `wfull=0`.
  - Required: `wdata` sequence `11,22,33,44,44` (`11^22^33^44=44`) on 5 consecutive cycles.
  - Required: `frame_done` pulses once; `frame_cnt=1`.
- **Back-to-back words.** Word A `32'h04030201` (`nb=3`, `last=0`) then word B `32'h000000AA` (`nb=0`, `last=1`), held valid.
  - Required: bytes `01,02,03,04,AA,AE` with no bubble.
  - Required: B is accepted on the edge of byte `04`.
- **Backpressure.** Same stimulus as the first scenario, with `wfull=1` forced for 10 cycles after byte `22` is accepted.
  - Required: `winc=1`, `wdata=33` held for all 10 cycles.
  - Required: the stream resumes `33,44,44`; the FIFO model receives exactly 5 bytes.
- **Partial word.** `32'hDEADBEEF`, `nb=1`, `last=1`.
  - Required: bytes `EF,BE,51`. `DE`/`AD` are never written.
- **Reset mid-frame.** Assert `rst_n=0` after byte `22` of the first scenario's stimulus.
  - Required: `winc=0` immediately and all outputs at reset values.
  - Required: a following fresh frame `32'h00000055` (`nb=0`) yields `55,55` and `frame_cnt=1`.
- **Counter wrap.** Preload by running `2^CNT_W` 1-byte frames (use `CNT_W=4` in sim: 16 frames).
  - Required: `frame_cnt` returns to 0 and `frame_done` pulses 16 times.
